// File: rtl/return_stack_ctrl.sv
// return_stack_ctrl: single-clock return stack for the Forth core.
// TOS lives in a register; the deeper entries live in a LUT RAM with an
// asynchronous read, so pop and next-on-stack need no extra latency.
// Optional macro RSTACK_NOS_EN adds the combinational next-on-stack port nos.
module return_stack_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  write_clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear_err,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] tos,
`ifdef RSTACK_NOS_EN
  output logic [DATA_WIDTH-1:0] nos,
`endif
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH+1)'(DEPTH);

  // Only DEPTH-1 slots are ever written; the array is sized to the full
  // address space so any ADDR_WIDTH-bit address decodes to a real word.
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic [DATA_WIDTH-1:0] tos_q, tos_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd;

  // Address arithmetic is modulo ADDR_WIDTH bits; out-of-range reads at
  // small depths are masked wherever the read data is consumed.
  assign wr_addr = depth_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign rd_addr = depth_q[ADDR_WIDTH-1:0] - ADDR_WIDTH'(2);
  assign ram_rd  = ram[rd_addr];

  assign empty = (depth_q == '0);
  assign full  = (depth_q == DEPTH_V);

  // Operation decode: illegal ops only raise a sticky flag; set beats clear.
  always_comb begin
    tos_d   = tos_q;
    depth_d = depth_q;
    ovf_d   = ovf_q & ~clear_err;
    unf_d   = unf_q & ~clear_err;
    ram_we  = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          ram_we  = !empty;
          tos_d   = data_in;
          depth_d = depth_q + 1'b1;
        end
      end
      2'b01: begin
        if (empty) begin
          unf_d = 1'b1;
        end else if (depth_q == (ADDR_WIDTH+1)'(1)) begin
          tos_d   = '0;
          depth_d = '0;
        end else begin
          tos_d   = ram_rd;
          depth_d = depth_q - 1'b1;
        end
      end
      2'b11: begin
        if (empty) unf_d = 1'b1;
        else       tos_d = data_in;
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge write_clock) begin
    if (reset) begin
      tos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Spill the old TOS into the RAM on a push; no reset so it maps to LUT RAM.
  always_ff @(posedge write_clock) begin
    if (ram_we && !reset) ram[wr_addr] <= tos_q;
  end

  assign tos       = tos_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef RSTACK_NOS_EN
  assign nos = (depth_q >= (ADDR_WIDTH+1)'(2)) ? ram_rd : '0;
`endif

endmodule

// File: doc/return_stack_ctrl.md
Name: return_stack_ctrl

Overview:
- Parametrised single-clock return stack for the Forth core; the second-generation return stack.
- Holds the top-of-stack (TOS) in a register and the remaining entries in an internal RAM array.
- Supports push, pop and replace (push and pop in the same cycle).
- Reports depth, full/empty status and sticky overflow/underflow error flags for the control unit's exception logic.

Parameters:
- DATA_WIDTH, 16, width of each stack entry.
- ADDR_WIDTH, 10, RAM address width. Total capacity is DEPTH = 2**ADDR_WIDTH entries: the TOS register plus DEPTH-1 RAM entries.

Ports:
- write_clock  input  1  sole clock; everything updates on its rising edge.
- reset  input  1  synchronous, active-high.
- push  input  1  push data_in this cycle.
- pop  input  1  pop this cycle.
- clear_err  input  1  clears the sticky error flags.
- data_in  input  DATA_WIDTH  value to push or replace with.
- tos  output  DATA_WIDTH  registered top-of-stack; 0 when empty.
- depth  output  ADDR_WIDTH+1  number of valid entries, 0..DEPTH.
- empty  output  1  depth == 0 (combinational from the depth register).
- full  output  1  depth == DEPTH (combinational from the depth register).
- overflow  output  1  sticky; set by an illegal push.
- underflow  output  1  sticky; set by an illegal pop or replace.

Behaviour:
- Reset (synchronous, write_clock edge with reset=1): tos=0, depth=0, overflow=0, underflow=0. RAM contents are don't-care. Reset overrides every other input in that cycle, including mid-sequence operations.
- Internal pointer sp = depth-1 when depth>0; it counts RAM entries in use. RAM entry k holds stack element k+2 counted from the top.
- RAM read is asynchronous at address sp-1, so there is no extra pop latency. The RAM is inferred as distributed/LUT RAM.
- All operations complete in one cycle. tos and depth reflect the operation on the edge that samples it.
- Operation table, evaluated each edge when reset=0:
  - Idle (push=0, pop=0): no change.
  - Push, not full: if depth>0, ram[depth-1] <= tos. Then tos <= data_in, depth <= depth+1.
  - Push, full: no state change; overflow <= 1.
  - Pop, depth>1: tos <= ram[depth-2], depth <= depth-1.
  - Pop, depth==1: tos <= 0, depth <= 0.
  - Pop, empty: no state change; underflow <= 1.
  - Replace (push=1, pop=1), depth>=1: tos <= data_in, depth unchanged, RAM untouched. Legal even when full.
  - Replace, empty: no state change; underflow <= 1.
- Sticky flags:
  - overflow and underflow stay set until clear_err=1 or reset.
  - clear_err in the same cycle as a new error: the set wins (flag ends at 1).
- Arithmetic:
  - depth is an unsigned ADDR_WIDTH+1-bit value and never wraps; illegal operations are blocked, not wrapped.
  - RAM address arithmetic is ADDR_WIDTH bits wide.
- tos is never X after reset. It reads 0 whenever depth==0.

Optional Feature:
- Macro RSTACK_NOS_EN.
- Defined: adds output port nos (output, DATA_WIDTH), the next-on-stack value. nos equals the RAM entry at address depth-2 when depth>=2, and 0 otherwise. It is driven combinationally from the asynchronous read already used for pop, so it updates in the same cycle as tos.
- Undefined: port nos is absent, with no extra logic. All other behaviour is identical.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> tos=0x3333, depth=3, empty=0; with RSTACK_NOS_EN, nos=0x2222.
- From the previous state, pop x3 -> tos goes 0x2222, 0x1111, 0; depth reaches 0 and empty=1. A 4th pop -> underflow=1, tos=0, depth=0.
- With ADDR_WIDTH=2, push 4 values 0xA0..0xA3 -> full=1. A 5th push of 0xFF -> overflow=1, tos=0xA3, depth=4. Then pop x4 returns 0xA2, 0xA1, 0xA0, 0 in order.
- With depth=2 and tos=0x0005, replace with data_in=0x0009 -> tos=0x0009, depth=2, and the next pop yields the original second entry. Replace on an empty stack -> underflow=1, tos stays 0.
- Set overflow, then pulse clear_err -> overflow=0. Assert clear_err together with an illegal pop -> underflow=1.
- Reset asserted mid-burst (push held high for 3 cycles, reset on the 2nd) -> tos=0, depth=0 and flags cleared on that edge; the 3rd push gives depth=1.
